// File: rtl/midori_column_share_collector_pkg.sv
// Shared constants, column offset helper and FSM state type
// for the Midori64 column share collector.
package midori_share_pkg;

    localparam int NUM_SHARES = 3;
    localparam int COL_W      = 16;
    localparam int NUM_COLS   = 4;
    localparam int DATA_W     = COL_W * NUM_COLS;

    localparam logic [5:0] TOP_OFF = 6'(DATA_W - COL_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column 0 is the most significant 16 bits of the state.
    function automatic logic [5:0] col_off(input logic [1:0] c);
        return TOP_OFF - {c, 4'b0000};
    endfunction

endpackage

// File: rtl/midori_column_share_collector_if.sv
// Handshake bundle: input share triple + randomness in,
// reshared triple out. master = producer/consumer, slave = collector.
interface midori_column_share_collector_if;
    import midori_share_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     group_out0;
    logic [DATA_W-1:0]     group_out1;
    logic [DATA_W-1:0]     group_out2;
    logic [2*COL_W-1:0]    rnd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     share_out0;
    logic [DATA_W-1:0]     share_out1;
    logic [DATA_W-1:0]     share_out2;
    logic                  busy;

    modport master (
        output in_valid, group_out0, group_out1, group_out2,
        output rnd_in, out_ready,
        input  in_ready, out_valid, busy,
        input  share_out0, share_out1, share_out2
    );

    modport slave (
        input  in_valid, group_out0, group_out1, group_out2,
        input  rnd_in, out_ready,
        output in_ready, out_valid, busy,
        output share_out0, share_out1, share_out2
    );

endinterface

// File: rtl/midori_column_share_collector_reshare.sv
// Combinational refresh of one 16-bit column of a 3-share state.
// Ports: s0..s2 in shares, r0/r1 randomness, o0..o2 out shares.
module midori_column_reshare
    import midori_share_pkg::*;
(
    input  logic [COL_W-1:0] s0,
    input  logic [COL_W-1:0] s1,
    input  logic [COL_W-1:0] s2,
    input  logic [COL_W-1:0] r0,
    input  logic [COL_W-1:0] r1,
    output logic [COL_W-1:0] o0,
    output logic [COL_W-1:0] o1,
    output logic [COL_W-1:0] o2
);

    logic [COL_W-1:0] t0;
    logic [COL_W-1:0] t1;
    logic [COL_W-1:0] t2;

    // Fold order keeps a fresh mask on every partial sum,
    // so the unshared column never appears on a wire.
    assign t0 = s0 ^ r0;
    assign t1 = t0 ^ s1;
    assign t2 = t1 ^ r1;
    assign o2 = t2 ^ s2;
    assign o0 = r0;
    assign o1 = r1;

endmodule

// File: rtl/midori_column_share_collector.sv
// Collects a 3-share Midori64 state and reshares it one column per
// cycle. Ports: clk, rst_n (sync, active-low), bus (slave side).
// Option MIDORI_COLLECTOR_UNMASK_EN adds pt_out (recombined value).
module midori_column_share_collector
    import midori_share_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    midori_column_share_collector_if.slave bus
`ifdef MIDORI_COLLECTOR_UNMASK_EN
    ,
    output logic [DATA_W-1:0] pt_out
`endif
);

    state_t            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [DATA_W-1:0] s0_q, s1_q, s2_q;
    logic [DATA_W-1:0] s0_d, s1_d, s2_d;
    logic [5:0]        off;
    logic [COL_W-1:0]  c0, c1, c2;
    logic [COL_W-1:0]  n0, n1, n2;
    logic              done;

    assign off = col_off(col_q);
    assign c0  = s0_q[off +: COL_W];
    assign c1  = s1_q[off +: COL_W];
    assign c2  = s2_q[off +: COL_W];

    midori_column_reshare u_reshare (
        .s0 (c0),
        .s1 (c1),
        .s2 (c2),
        .r0 (bus.rnd_in[COL_W-1:0]),
        .r1 (bus.rnd_in[2*COL_W-1:COL_W]),
        .o0 (n0),
        .o1 (n1),
        .o2 (n2)
    );

    // Results are written back in place over the captured shares.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    s0_d    = bus.group_out0;
                    s1_d    = bus.group_out1;
                    s2_d    = bus.group_out2;
                    col_d   = 2'd0;
                    state_d = PROC;
                end
            end
            PROC: begin
                s0_d[off +: COL_W] = n0;
                s1_d[off +: COL_W] = n1;
                s2_d[off +: COL_W] = n2;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    // Shares are only exposed once all columns are refreshed.
    assign done           = (state_q == DONE);
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q == PROC);
    assign bus.out_valid  = done;
    assign bus.share_out0 = done ? s0_q : '0;
    assign bus.share_out1 = done ? s1_q : '0;
    assign bus.share_out2 = done ? s2_q : '0;

`ifdef MIDORI_COLLECTOR_UNMASK_EN
    logic [DATA_W-1:0] pt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pt_q <= '0;
        end else if (state_d == DONE) begin
            pt_q <= s0_d ^ s1_d ^ s2_d;
        end else begin
            pt_q <= '0;
        end
    end

    assign pt_out = pt_q;
`endif

endmodule
